// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer for a registered 1-bit ALU slice.
// Feeds one operand bit per clock to the slice, chains the slice carry back
// in, collects the returning result bits and resolves SLT, NOR and flags locally.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready; waiting for start, outputs hold the last result
// S_RUN   | driving bit cnt to the slice, capturing bit cnt-1
// S_DRAIN | slice returns the MSB; final result and flags registered
// S_DONE  | done pulse for one cycle
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [3:0]       alu_ctl,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_binv,
  output logic             slice_less,
  output logic [1:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       ctl_reg;
  // MSB is never stored: it arrives on the DRAIN cycle and is used directly.
  logic [WIDTH-2:0] res;
  logic             cin_msb;

  logic             is_sub, is_arith, is_logic_or, is_add_sub, is_legal;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] final_res;
  logic             ovf;

  // Decode of the latched operation.
  always_comb begin
    is_sub      = (ctl_reg == OP_SUB) || (ctl_reg == OP_SLT);
    is_add_sub  = (ctl_reg == OP_ADD) || (ctl_reg == OP_SUB);
    is_arith    = is_add_sub || (ctl_reg == OP_SLT);
    is_logic_or = (ctl_reg == OP_OR) || (ctl_reg == OP_NOR);
    is_legal    = is_arith || is_logic_or || (ctl_reg == OP_AND);
  end

  // Final result assembly; valid only during DRAIN when the MSB is on slice_result.
  always_comb begin
    full_res  = {slice_result, res};
    ovf       = cin_msb ^ slice_cout;
    final_res = '0;
    case (ctl_reg)
      OP_AND, OP_OR, OP_ADD, OP_SUB: final_res = full_res;
      OP_NOR:                        final_res = ~full_res;
      OP_SLT:                        final_res = {{(WIDTH-1){1'b0}}, full_res[WIDTH-1] ^ ovf};
      default:                       final_res = '0;
    endcase
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (cnt == CNT_LAST) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Slice drive: active only in RUN, carry chained from the registered slice cout.
  always_comb begin
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_binv = 1'b0;
    slice_less = 1'b0;
    slice_op   = 2'b00;
    if (state == S_RUN) begin
      slice_a    = a_reg[cnt];
      slice_b    = b_reg[cnt];
      slice_binv = is_sub;
      slice_cin  = (cnt == '0) ? is_sub : slice_cout;
      if (is_arith)         slice_op = 2'b10;
      else if (is_logic_or) slice_op = 2'b01;
      else                  slice_op = 2'b00;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Operand latch, bit counter, result capture and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      ctl_reg   <= '0;
      res       <= '0;
      cin_msb   <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg   <= inA;
            b_reg   <= inB;
            ctl_reg <= alu_ctl;
            cnt     <= '0;
            illegal <= 1'b0;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt != '0) res[cnt - 1'b1] <= slice_result;
          if (cnt == CNT_LAST) cin_msb <= slice_cout;
        end
        S_DRAIN: begin
          result    <= final_res;
          zero      <= (final_res == '0);
          overflow  <= is_arith ? ovf : 1'b0;
          carry_out <= is_add_sub ? slice_cout : 1'b0;
          illegal   <= ~is_legal;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for alu_serial_seq at WIDTH=8 with a
// behavioural registered 1-bit slice.
module tb_alu_serial_seq;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] inA, inB;
  logic [3:0]   alu_ctl;
  logic         ready, done, zero, overflow, carry_out, illegal;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_binv, slice_less;
  logic [1:0]   slice_op;
  logic         slice_result, slice_cout;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         co;
    logic         il;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .inA(inA), .inB(inB),
    .alu_ctl(alu_ctl), .ready(ready), .done(done), .result(result),
    .zero(zero), .overflow(overflow), .carry_out(carry_out), .illegal(illegal),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_binv(slice_binv), .slice_less(slice_less), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout)
  );

  always #5 clock = ~clock;

  // Registered 1-bit ALU slice model.
  always @(posedge clock) begin
    logic bb;
    if (reset) begin
      slice_result <= 1'b0;
      slice_cout   <= 1'b0;
    end else begin
      bb = slice_b ^ slice_binv;
      case (slice_op)
        2'b00:   slice_result <= slice_a & bb;
        2'b01:   slice_result <= slice_a | bb;
        2'b10:   slice_result <= slice_a ^ bb ^ slice_cin;
        default: slice_result <= 1'b0;
      endcase
      slice_cout <= (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result",    32'(result),    32'(e.res));
        check("zero",      32'(zero),      32'(e.z));
        check("overflow",  32'(overflow),  32'(e.ov));
        check("carry_out", 32'(carry_out), 32'(e.co));
        check("illegal",   32'(illegal),   32'(e.il));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (!ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ez, input logic eo,
                       input logic ec, input logic ei, input logic chk_slice,
                       input logic [1:0] sop, input logic sbinv, input logic scin,
                       input logic poke);
    int lat;
    exp_t e;
    wait_ready();
    start   = 1'b1;
    inA     = a;
    inB     = b;
    alu_ctl = ctl;
    e.res = er; e.z = ez; e.ov = eo; e.co = ec; e.il = ei;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_accept", 32'(ready),   32'd0);
    check("illegal_cleared",   32'(illegal), 32'd0);
    if (chk_slice) begin
      check("slice_op0",   32'(slice_op),   32'(sop));
      check("slice_binv0", 32'(slice_binv), 32'(sbinv));
      check("slice_cin0",  32'(slice_cin),  32'(scin));
      check("slice_a0",    32'(slice_a),    32'(a[0]));
      check("slice_b0",    32'(slice_b),    32'(b[0]));
    end
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock);
      #1;
      if (poke && n == 3) begin
        start   = 1'b1;
        inA     = 8'hAA;
        inB     = 8'h55;
        alu_ctl = 4'b0001;
      end
      if (poke && n == 4) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("done_latency", 32'(lat), 32'(W + 1));
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; inA = '0; inB = '0; alu_ctl = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags",  32'({zero, overflow, carry_out, illegal}), 32'd0);
    check("rst_slice",  32'({slice_a, slice_b, slice_cin, slice_binv, slice_less, slice_op}), 32'd0);
    reset = 1'b0;

    //     ctl      a      b      res    z     ov    co    il    chk   op     binv  cin   poke
    do_op(4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    do_op(4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    do_op(4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    do_op(4'b0111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    do_op(4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    do_op(4'b0001, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    do_op(4'b1100, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    do_op(4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    do_op(4'b0110, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);

    // Abort mid-RUN at cnt=3: no expectation is queued, so any done is flagged.
    wait_ready();
    start = 1'b1; inA = 8'h7F; inB = 8'h01; alu_ctl = 4'b0010;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_ready",  32'(ready),  32'd1);
    check("abort_done",   32'(done),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    seen_done = 0;
    repeat (15) begin
      @(posedge clock);
      #1;
      if (done) seen_done = 1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    do_op(4'b1111, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    do_op(4'b0000, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
